// File: rtl/alu_seq_sched.sv
// alu_seq_sched: round-robin scheduler that shares one opcode-driven ALU
// between two requesters. The winner's program select is latched at grant,
// then a fixed opcode program is played out one opcode per slot (each slot
// held HOLD un-stalled cycles), closed by a one-cycle done pulse.
// Optional build macro: ALU_SEQ_SCHED_ABORT_EN -- when defined, dropping the
// granted request mid-program aborts it without a done pulse.
module alu_seq_sched #(
    parameter int OPW     = 4,
    parameter int IDLE_OP = 0,
    parameter int HOLD    = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req,
    input  logic [1:0]     mode,
    input  logic           stall,
    output logic [1:0]     gnt,
    output logic [OPW-1:0] op,
    output logic           op_valid,
    output logic [3:0]     step,
    output logic [1:0]     done
);

    localparam int             CW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD - 1);
    localparam logic [OPW-1:0] IDLE_CODE = OPW'(IDLE_OP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           prog_q, prog_d;     // latched program select of the winner
    logic           last_q, last_d;     // requester granted most recently
    logic [1:0]     gnt_d, done_d;
    logic [OPW-1:0] op_d;
    logic           vld_d;
    logic [3:0]     step_d;

    logic           win;
    logic           pick;
    logic           hold_end;
    logic           last_step;
    logic           complete;
    logic           abort_now;

    // Fixed opcode tables: program 0 has 9 slots, program 1 has 5.
    function automatic logic [OPW-1:0] prog_op(input logic prog, input logic [3:0] idx);
        logic [3:0] code;
        code = 4'd0;
        if (!prog) begin
            case (idx)
                4'd0: code = 4'd2;
                4'd1: code = 4'd1;
                4'd2: code = 4'd5;
                4'd3: code = 4'd4;
                4'd4: code = 4'd3;
                4'd5: code = 4'd1;
                4'd6: code = 4'd1;
                4'd7: code = 4'd6;
                4'd8: code = 4'd4;
                default: code = 4'd0;
            endcase
        end else begin
            case (idx)
                4'd0: code = 4'd1;
                4'd1: code = 4'd5;
                4'd2: code = 4'd3;
                4'd3: code = 4'd1;
                4'd4: code = 4'd1;
                default: code = 4'd0;
            endcase
        end
        return OPW'(code);
    endfunction

    // The running requester is whichever grant bit is set; with both
    // requesting, the one not granted last wins.
    assign win       = gnt[1];
    assign pick      = (req == 2'b11) ? ~last_q : req[1];
    assign hold_end  = (cnt_q == HOLD_LAST);
    assign last_step = (step == (prog_q ? 4'd4 : 4'd8));
    assign complete  = !stall && hold_end && last_step;

`ifdef ALU_SEQ_SCHED_ABORT_EN
    // A drop coinciding with the final advance is treated as completion.
    assign abort_now = !req[win] && !complete;
`else
    assign abort_now = 1'b0;
`endif

    // State and registered outputs; reset leaves requester 0 first in line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prog_q   <= 1'b0;
            last_q   <= 1'b1;
            gnt      <= 2'b00;
            op       <= IDLE_CODE;
            op_valid <= 1'b0;
            step     <= 4'd0;
            done     <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prog_q   <= prog_d;
            last_q   <= last_d;
            gnt      <= gnt_d;
            op       <= op_d;
            op_valid <= vld_d;
            step     <= step_d;
            done     <= done_d;
        end
    end

    // Next-state: arbitrate in IDLE, finish or abort in RUN, one FIN cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (req != 2'b00) state_d = S_RUN;
            S_RUN:   if (complete || abort_now) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next output values: grant and first opcode, slot advance, wrap-up.
    always_comb begin
        gnt_d  = gnt;
        op_d   = op;
        vld_d  = op_valid;
        step_d = step;
        done_d = 2'b00;
        cnt_d  = cnt_q;
        prog_d = prog_q;
        last_d = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    gnt_d  = pick ? 2'b10 : 2'b01;
                    prog_d = mode[pick];
                    step_d = 4'd0;
                    op_d   = prog_op(mode[pick], 4'd0);
                    vld_d  = 1'b1;
                    cnt_d  = '0;
                end else begin
                    gnt_d  = 2'b00;
                    op_d   = IDLE_CODE;
                    vld_d  = 1'b0;
                    step_d = 4'd0;
                end
            end
            S_RUN: begin
                if (complete || abort_now) begin
                    gnt_d  = 2'b00;
                    op_d   = IDLE_CODE;
                    vld_d  = 1'b0;
                    step_d = 4'd0;
                    cnt_d  = '0;
                    last_d = win;
                    if (complete) done_d = win ? 2'b10 : 2'b01;
                end else if (!stall) begin
                    if (hold_end) begin
                        cnt_d  = '0;
                        step_d = step + 4'd1;
                        op_d   = prog_op(prog_q, step + 4'd1);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                gnt_d  = 2'b00;
                op_d   = IDLE_CODE;
                vld_d  = 1'b0;
                step_d = 4'd0;
            end
            default: begin
                gnt_d  = 2'b00;
                op_d   = IDLE_CODE;
                vld_d  = 1'b0;
                step_d = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_seq_sched.sv
// Bench for alu_seq_sched: directed scenarios with literal expectations plus
// a randomized phase, all compared every cycle against a queue-based model.
module tb_alu_seq_sched;

    localparam int OPW     = 4;
    localparam int IDLE_OP = 0;
    localparam int HOLD    = 1;

    logic           clk   = 1'b0;
    logic           rst   = 1'b0;
    logic [1:0]     req   = 2'b00;
    logic [1:0]     mode  = 2'b00;
    logic           stall = 1'b0;
    logic [1:0]     gnt;
    logic [OPW-1:0] op;
    logic           op_valid;
    logic [3:0]     step;
    logic [1:0]     done;

    int checks   = 0;
    int failures = 0;

    alu_seq_sched #(.OPW(OPW), .IDLE_OP(IDLE_OP), .HOLD(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .mode     (mode),
        .stall    (stall),
        .gnt      (gnt),
        .op       (op),
        .op_valid (op_valid),
        .step     (step),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Program tables as listed for the block.
    int prog_tbl [2][9] = '{'{2, 1, 5, 4, 3, 1, 1, 6, 4}, '{1, 5, 3, 1, 1, 0, 0, 0, 0}};
    int prog_len [2]    = '{9, 5};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A granted program is expanded into a queue of (opcode, index) slots,
    // each repeated HOLD times; every un-stalled cycle consumes one slot.
    typedef struct packed {
        int op;
        int idx;
    } slot_t;

    slot_t          mq[$];
    bit             m_fin  = 1'b0;
    int             m_win  = 0;
    int             m_last = 1;
    bit             m_ends;
    bit             m_drop;
    logic [1:0]     e_gnt  = 2'b00;
    logic [1:0]     e_done = 2'b00;
    logic [OPW-1:0] e_op   = OPW'(IDLE_OP);
    logic [3:0]     e_step = 4'd0;
    logic           e_vld  = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_fin  = 1'b0;
            m_last = 1;
            e_gnt  = 2'b00;
            e_done = 2'b00;
            e_op   = OPW'(IDLE_OP);
            e_step = 4'd0;
            e_vld  = 1'b0;
        end else begin
            e_done = 2'b00;
            if (m_fin) begin
                m_fin = 1'b0;
            end else if (mq.size() != 0) begin
                m_ends = !stall && (mq.size() == 1);
                m_drop = 1'b0;
`ifdef ALU_SEQ_SCHED_ABORT_EN
                m_drop = !req[m_win] && !m_ends;
`endif
                if (m_ends || m_drop) begin
                    mq.delete();
                    m_fin  = 1'b1;
                    m_last = m_win;
                    e_gnt  = 2'b00;
                    e_vld  = 1'b0;
                    e_op   = OPW'(IDLE_OP);
                    if (m_ends) e_done = (m_win == 1) ? 2'b10 : 2'b01;
                end else begin
                    if (!stall) void'(mq.pop_front());
                    e_op   = OPW'(mq[0].op);
                    e_step = 4'(mq[0].idx);
                end
            end else if (req != 2'b00) begin
                if (req == 2'b11) m_win = 1 - m_last;
                else              m_win = req[1] ? 1 : 0;
                for (int i = 0; i < prog_len[mode[m_win]]; i++)
                    for (int h = 0; h < HOLD; h++)
                        mq.push_back('{op: prog_tbl[mode[m_win]][i], idx: i});
                e_gnt  = (m_win == 1) ? 2'b10 : 2'b01;
                e_vld  = 1'b1;
                e_op   = OPW'(mq[0].op);
                e_step = 4'd0;
            end else begin
                e_gnt = 2'b00;
                e_vld = 1'b0;
                e_op  = OPW'(IDLE_OP);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("m_gnt", int'(gnt), int'(e_gnt));
            chk("m_op_valid", int'(op_valid), int'(e_vld));
            chk("m_done", int'(done), int'(e_done));
            if (e_vld) begin
                chk("m_op", int'(op), int'(e_op));
                chk("m_step", int'(step), int'(e_step));
            end else begin
                chk("m_op_idle", int'(op), IDLE_OP);
            end
        end
    end

    // Runs until a done pulse (or budget expiry), counting valid cycles.
    task automatic run_to_done(input string nm, input logic [1:0] who, input int budget,
                               output int vcnt);
        bit seen;
        seen = 1'b0;
        vcnt = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (op_valid) vcnt++;
            if (done != 2'b00) begin
                seen = 1'b1;
                chk(nm, int'(done), int'(who));
            end
        end
        chk({nm, "_seen"}, int'(seen), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int          vcnt, s2, ng, gap;
    bit          found, prev_vld;
    logic [1:0]  grants [3];

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_vld", int'(op_valid), 0);
        chk("rst_op", int'(op), IDLE_OP);
        chk("rst_step", int'(step), 0);
        chk("rst_done", int'(done), 0);

        // Program 0 for requester 0.
        rst = 1'b1; req = 2'b01; mode = 2'b00;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("p0_op", int'(op), prog_tbl[0][i]);
            chk("p0_step", int'(step), i);
            chk("p0_gnt", int'(gnt), 1);
            chk("p0_vld", int'(op_valid), 1);
        end
        @(negedge clk);
        chk("p0_done", int'(done), 1);
        chk("p0_end_vld", int'(op_valid), 0);
        req = 2'b00;

        // Program 1 for requester 1.
        repeat (2) @(negedge clk);
        req = 2'b10; mode = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("p1_op", int'(op), prog_tbl[1][i]);
            chk("p1_step", int'(step), i);
            chk("p1_gnt", int'(gnt), 2);
        end
        @(negedge clk);
        chk("p1_done", int'(done), 2);
        req = 2'b00;

        // Stall for three cycles while slot 2 of program 0 is presented.
        repeat (2) @(negedge clk);
        req = 2'b01; mode = 2'b00;
        vcnt = 0; s2 = 0; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (op_valid) vcnt++;
            if (op_valid && step == 4'd2) s2++;
            stall = op_valid && (step == 4'd2) && (s2 <= 3);
            if (done != 2'b00) found = 1'b1;
        end
        stall = 1'b0; req = 2'b00;
        chk("stall_len", vcnt, 12);
        chk("stall_hold", s2, 4);
        chk("stall_done", int'(found), 1);

        // Both requesting continuously: grants alternate starting with 0.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1; req = 2'b11; mode = 2'b11;
        ng = 0; gap = 0; prev_vld = 1'b0;
        for (int i = 0; i < 60 && ng < 3; i++) begin
            @(negedge clk);
            if (op_valid && !prev_vld) begin
                grants[ng] = gnt;
                ng++;
            end
            if (ng == 1 && !op_valid) gap++;
            prev_vld = op_valid;
        end
        chk("rr_count", ng, 3);
        chk("rr_g0", int'(grants[0]), 1);
        chk("rr_g1", int'(grants[1]), 2);
        chk("rr_g2", int'(grants[2]), 1);
        chk("rr_gap", gap, 2);
        run_to_done("rr3_done", 2'b01, 30, vcnt);
        req = 2'b00;

        // Asynchronous reset in the middle of a program.
        repeat (2) @(negedge clk);
        req = 2'b01; mode = 2'b00; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (op_valid && step == 4'd4) found = 1'b1;
        end
        chk("ar_reach", int'(found), 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_gnt", int'(gnt), 0);
        chk("ar_vld", int'(op_valid), 0);
        chk("ar_op", int'(op), IDLE_OP);
        chk("ar_done", int'(done), 0);
        repeat (2) begin
            @(negedge clk);
            chk("ar_nodone", int'(done), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("ar_restart_step", int'(step), 0);
        chk("ar_restart_op", int'(op), 2);
        chk("ar_restart_gnt", int'(gnt), 1);
        run_to_done("ar_done_end", 2'b01, 30, vcnt);
        req = 2'b00;

        // Request dropped at slot 3.
        repeat (2) @(negedge clk);
        req = 2'b01; mode = 2'b00; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (op_valid && step == 4'd3) found = 1'b1;
        end
        chk("ab_reach", int'(found), 1);
        req = 2'b00;
`ifdef ALU_SEQ_SCHED_ABORT_EN
        @(negedge clk);
        chk("ab_vld", int'(op_valid), 0);
        chk("ab_gnt", int'(gnt), 0);
        chk("ab_done", int'(done), 0);
        @(negedge clk);
        chk("ab_done2", int'(done), 0);
`else
        run_to_done("noab_done", 2'b01, 30, vcnt);
        chk("noab_rest", vcnt, 5);
`endif

        // Randomized traffic; the compare process checks every cycle.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            stall = ($urandom_range(0, 3) == 0);
        end
        req = 2'b00; stall = 1'b0;
        repeat (30) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_sched.md
Name: alu_seq_sched

Overview:
- Schedules a shared 4-bit-opcode ALU between two requesters.
- Round-robin arbiter picks a requester, latches its program select, then plays a fixed opcode program to the ALU, one opcode per slot.
- Sits between requester control FSMs and the ALU opcode input.
- Ends each program with a per-requester done pulse.

Parameters:
- OPW, 4: opcode width.
- IDLE_OP, 0: opcode driven while no program runs.
- HOLD, 1: cycles each opcode is held (>=1); counted only when not stalled.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- req  input  2  request, one bit per requester; level, held until done.
- mode  input  2  program select per requester; mode[i] sampled at grant of i.
- stall  input  1  ALU busy; freezes current opcode, hold counter and step.
- gnt  output  2  one-hot grant; high for the whole program.
- op  output  OPW  opcode to ALU.
- op_valid  output  1  op is a program opcode.
- step  output  4  index of current opcode within program.
- done  output  2  one-cycle pulse to the finished requester.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, gnt=0, op=IDLE_OP, op_valid=0, step=0, done=0.
  - Round-robin pointer set so requester 0 wins first.
- Program tables, fixed:
  - P0 (mode=0), 9 ops: 2,1,5,4,3,1,1,6,4.
  - P1 (mode=1), 5 ops: 1,5,3,1,1.
- States: IDLE, RUN, FIN. All outputs registered.
- IDLE:
  - If req!=0, next edge goes to RUN with gnt one-hot to the winner.
  - Winner: sole requester; if both request, the one not granted last.
  - Same edge: latch winner's mode, step=0, op=first opcode, op_valid=1.
  - Latency req->op_valid is 1 cycle.
- RUN:
  - Hold counter increments each cycle stall=0. At HOLD-1 it clears and step advances, op=table[step+1].
  - stall=1 holds op, step and counter unchanged.
  - On the last step's advance, next edge goes to FIN: op_valid=0, op=IDLE_OP, gnt=0, done[winner]=1, pointer updated.
- FIN:
  - One cycle, done cleared at next edge, state returns to IDLE.
  - req is not sampled in FIN, so there is a minimum 1-cycle gap between programs.
  - A requester still holding req is re-arbitrated in IDLE.
- Program atomicity: req or mode changes during RUN are ignored (no abort unless feature enabled).
- stall in IDLE/FIN: no effect.
- Async reset mid-RUN aborts immediately, with no done pulse.
- Step width 4 covers max length 9; no wrap within a program.
- Program duration: length*HOLD cycles plus stall cycles.

Optional Feature:
- Macro: ALU_SEQ_SCHED_ABORT_EN.
- Enabled:
  - If req[winner] drops during RUN, next edge goes to FIN-equivalent: op_valid=0, op=IDLE_OP, gnt=0.
  - done is not pulsed; pointer is still updated; returns to IDLE after one cycle.
  - A drop in the same cycle as the last step's advance counts as normal completion (done pulses).
- Disabled: req deassertion in RUN ignored; program always completes.

Test Plan:
- Reset then req=01, mode=00, HOLD=1, stall=0 -> op_valid at cycle 1; op sequence 2,1,5,4,3,1,1,6,4 on 9 consecutive cycles; done=01 one cycle after last op; gnt=01 throughout.
- req=10, mode=10 -> P1 sequence 1,5,3,1,1 with gnt=10; done=10 pulse; step 0..4.
- req=11 held continuously -> grants alternate 01,10,01; one idle FIN cycle plus one IDLE cycle between programs; no starvation.
- Stall=1 for 3 cycles during step 2 of P0 -> op=5 held 4 cycles total; remaining sequence unchanged; total program 12 cycles.
- Async rst=0 pulse mid-RUN (step 4) -> outputs immediately gnt=0, op_valid=0, op=0, no done; after release, req=01 restarts at step 0.
- ABORT_EN defined, drop req[0] at step 3 -> next cycle op_valid=0, gnt=0, done stays 0. Undefined -> full program and done pulse.
